mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: memArbiter

---
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port dataMemory arbiter (req/we/addr/wdata in, ack/err/rdata out per port; memAddress/memWriteData/memWrite/memRead bus, memReadData in; busy)
module mem_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] memReadData,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic        memRead,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, nextState;
  logic lastGrant, gntId, latWe, latErr, grant, selWe, selErr;
  logic [31:0] selAddr, selWdata;
  always_comb begin
    grant = (req0 && req1) ? !lastGrant : !req0;
    selWe = grant ? we1 : we0;
    selAddr = grant ? addr1 : addr0;
    selWdata = grant ? wdata1 : wdata0;
    selErr = selAddr >= 32'(DEPTH);
    nextState = (state == IDLE) ? ((req0 || req1) ? ACCESS : IDLE) :
                (state == ACCESS) ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lastGrant <= 1'b1;
      gntId <= 1'b0;
      latWe <= 1'b0;
      latErr <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      memAddress <= '0;
      memWriteData <= '0;
      memWrite <= 1'b0;
      memRead <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      memAddress <= '0;
      memWriteData <= '0;
      memWrite <= 1'b0;
      memRead <= 1'b0;
      if (state == IDLE && (req0 || req1)) begin
        gntId <= grant;
        latWe <= selWe;
        latErr <= selErr;
        memAddress <= selAddr;
        memWriteData <= selWdata;
        memWrite <= selWe && !selErr;
        memRead <= !selWe && !selErr;
      end
      if (state == ACCESS) begin
        if (!latWe && !latErr && gntId) rdata1 <= memReadData;
        if (!latWe && !latErr && !gntId) rdata0 <= memReadData;
        ack0 <= !gntId;
        ack1 <= gntId;
        err0 <= !gntId && latErr;
        err1 <= gntId && latErr;
      end
      if (state == RESP) lastGrant <= gntId;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction-level checks of mem_arbiter against a spec-level model
module tb_mem_arbiter;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset, req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, memReadData;
  logic ack0, ack1, err0, err1, memWrite, memRead, busy;
  logic [31:0] rdata0, rdata1, memAddress, memWriteData;
  logic [31:0] tbMem [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
  logic [31:0] refMem [8];
  logic [31:0] refRd [2];
  int lastG;
  int nCmp = 0;
  int nBad = 0;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .memReadData(memReadData), .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .memAddress(memAddress),
    .memWriteData(memWriteData), .memWrite(memWrite), .memRead(memRead), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (memWrite && memAddress < 32'(DEPTH)) tbMem[memAddress[2:0]] <= memWriteData;

  assign memReadData = (memAddress < 32'(DEPTH)) ? tbMem[memAddress[2:0]] : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge with the arbiter idle; covers six cycles, enough
  // for two serialized grants, and returns at #1 after the sixth posedge.
  task automatic runTxn(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                        input bit wig);
    bit r [2];
    bit w [2];
    bit er [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] oldRd [2];
    logic [31:0] expA, expD;
    int accC [2];
    int ackC [2];
    int order [$];
    int p;
    r[0] = r0; r[1] = r1; w[0] = w0; w[1] = w1;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    oldRd[0] = refRd[0]; oldRd[1] = refRd[1];
    accC[0] = -1; accC[1] = -1; ackC[0] = -1; ackC[1] = -1;
    er[0] = 1'b0; er[1] = 1'b0;
    if (r0 && r1) order = (lastG == 1) ? '{0, 1} : '{1, 0};
    else if (r0) order = '{0};
    else if (r1) order = '{1};
    foreach (order[i]) begin
      p = order[i];
      accC[p] = 2 + 3 * i;
      ackC[p] = 3 + 3 * i;
      er[p] = a[p] >= 32'(DEPTH);
      if (!er[p] && w[p]) refMem[a[p][2:0]] = d[p];
      if (!er[p] && !w[p]) refRd[p] = refMem[a[p][2:0]];
      lastG = p;
    end
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      chk("ack0", ack0, cyc == ackC[0]);
      chk("ack1", ack1, cyc == ackC[1]);
      chk("err0", err0, cyc == ackC[0] && er[0]);
      chk("err1", err1, cyc == ackC[1] && er[1]);
      chk("busy", busy, cyc == accC[0] || cyc == ackC[0] || cyc == accC[1] || cyc == ackC[1]);
      chk("memWrite", memWrite, (cyc == accC[0] && w[0] && !er[0]) || (cyc == accC[1] && w[1] && !er[1]));
      chk("memRead", memRead, (cyc == accC[0] && !w[0] && !er[0]) || (cyc == accC[1] && !w[1] && !er[1]));
      expA = (cyc == accC[0]) ? a[0] : (cyc == accC[1]) ? a[1] : 32'd0;
      expD = (cyc == accC[0]) ? d[0] : (cyc == accC[1]) ? d[1] : 32'd0;
      chk("memAddress", memAddress, expA);
      chk("memWriteData", memWriteData, expD);
      chk("rdata0", rdata0, (ackC[0] > 0 && cyc >= ackC[0]) ? refRd[0] : oldRd[0]);
      chk("rdata1", rdata1, (ackC[1] > 0 && cyc >= ackC[1]) ? refRd[1] : oldRd[1]);
      @(posedge clk);
      #1;
      if (cyc == ackC[0]) req0 = 1'b0;
      if (cyc == ackC[1]) req1 = 1'b0;
      if (wig && cyc == 1) begin
        addr0 = addr0 + 32'd2; addr1 = addr1 + 32'd2;
        wdata0 = ~wdata0; wdata1 = ~wdata1;
      end
    end
  endtask

  function automatic logic [31:0] rndAddr();
    return ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 11));
  endfunction

  initial begin
    bit r0, r1;
    reset = 1'b0;
    {req0, req1, we0, we1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 32'(i);
    refRd[0] = '0; refRd[1] = '0;
    lastG = 1;
    @(negedge clk);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_memWrite", memWrite, 1'b0);
    chk("rst_memRead", memRead, 1'b0);
    chk("rst_memAddress", memAddress, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    runTxn(1, 0, 32'd1, 32'd0, 1, 0, 32'd2, 32'd0, 0);
    runTxn(1, 0, 32'd1, 32'd0, 1, 0, 32'd2, 32'd0, 0);
    runTxn(1, 0, 32'd5, 32'd0, 0, 0, 32'd0, 32'd0, 0);
    runTxn(0, 0, 32'd0, 32'd0, 1, 1, 32'd3, 32'hDEADBEEF, 0);
    runTxn(0, 0, 32'd0, 32'd0, 1, 0, 32'd3, 32'd0, 0);
    runTxn(1, 1, 32'd8, 32'h1234_5678, 0, 0, 32'd0, 32'd0, 0);
    runTxn(1, 1, 32'h8000_0002, 32'h0BAD_F00D, 0, 0, 32'd0, 32'd0, 0);
    runTxn(1, 0, 32'd4, 32'd0, 0, 0, 32'd0, 32'd0, 1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd2; wdata0 = 32'h55;
    @(posedge clk);
    #1;
    chk("mid_memWrite_before", memWrite, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_memWrite", memWrite, 1'b0);
    chk("mid_memRead", memRead, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_memAddress", memAddress, 32'd0);
    chk("mid_memWriteData", memWriteData, 32'd0);
    chk("mid_ack0", ack0, 1'b0);
    chk("mid_rdata0", rdata0, 32'd0);
    chk("mid_rdata1", rdata1, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("mid_word2", tbMem[2], refMem[2]);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    refRd[0] = '0; refRd[1] = '0;
    lastG = 1;
    @(negedge clk);
    chk("post_ack0", ack0, 1'b0);
    chk("post_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      runTxn(r0, 1'($urandom), rndAddr(), $urandom, r1, 1'($urandom), rndAddr(), $urandom, 0);
    end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) chk("mem_final", tbMem[i], refMem[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
